// File: rtl/xg_mac_pkg.sv
// Shared 10G MAC definitions: TX arbiter state encoding, beat-width default and tkeep popcount.
package xg_mac_pkg;

   localparam int unsigned DEF_DATA_BYTES = 8;
   localparam int unsigned KEEP_MAX       = 64;
   localparam int unsigned KEEP_CNT_BITS  = 7;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_PASS    = 2'd1,
      ARB_DISCARD = 2'd2
   } arb_state_t;

   // Number of valid bytes in a beat; callers zero-extend their tkeep to KEEP_MAX bits.
   function automatic logic [KEEP_CNT_BITS-1:0] popcount(input logic [KEEP_MAX-1:0] keep);
      logic [KEEP_CNT_BITS-1:0] n;
      n = '0;
      for (int i = 0; i < int'(KEEP_MAX); i++) begin
         n = n + KEEP_CNT_BITS'(keep[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/xg_tx_frame_arbiter_if.sv
// AXI-Stream bundle with LANES parallel lanes; tid carries the source tag on the merged side.
interface xg_tx_frame_arbiter_if #(
   parameter int unsigned LANES      = 1,
   parameter int unsigned DATA_BYTES = 8,
   parameter int unsigned ID_BITS    = 2
);
   localparam int unsigned DATA_BITS = DATA_BYTES * 8;

   logic [LANES*DATA_BITS-1:0]  tdata;
   logic [LANES*DATA_BYTES-1:0] tkeep;
   logic [LANES-1:0]            tvalid;
   logic [LANES-1:0]            tlast;
   logic [LANES-1:0]            tuser;
   logic [LANES-1:0]            tready;
   logic [ID_BITS-1:0]          tid;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, tid, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tid, output tready);

endinterface

// File: rtl/xg_tx_frame_arbiter_rr_pick.sv
// Circular priority search: first set request strictly after 'last', wrapping around.
module rr_pick #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned ID_BITS   = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [ID_BITS-1:0]   last,
   output logic                 any,
   output logic [ID_BITS-1:0]   idx
);

   int pos;

   // Walk from the farthest candidate to the nearest so the nearest one wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = int'(NUM_PORTS); k >= 1; k--) begin
         pos = (int'(last) + k) % int'(NUM_PORTS);
         if (req[ID_BITS'(pos)]) begin
            any = 1'b1;
            idx = ID_BITS'(pos);
         end
      end
   end

endmodule

// File: rtl/xg_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC TX datapath through a one-deep output register,
// cutting frames that exceed MAX_FRAME_BYTES.
module xg_tx_frame_arbiter
   import xg_mac_pkg::*;
#(
   parameter int unsigned DATA_BYTES      = DEF_DATA_BYTES,
   parameter int unsigned DATA_BITS       = DATA_BYTES * 8,
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned ID_BITS         = $clog2(NUM_PORTS),
   parameter int unsigned MAX_FRAME_BYTES = 1522
) (
   input  logic                   clock,
   input  logic                   aresetn,
   xg_tx_frame_arbiter_if.slave   saxis,
   xg_tx_frame_arbiter_if.master  maxis,
   output logic [31:0]            truncated_count
);

   arb_state_t               state, state_next;
   logic [ID_BITS-1:0]       grant, rr;
   logic [15:0]              bytes;
   logic                     pick_any;
   logic [ID_BITS-1:0]       pick_idx;
   logic [NUM_PORTS-1:0]     ready_c;

   logic                     in_valid, in_last, in_user;
   logic [DATA_BITS-1:0]     in_data;
   logic [DATA_BYTES-1:0]    in_keep;
   logic                     out_ready, accept, over;
   logic [16:0]              bytes_sum;
   logic [15:0]              bytes_next;

   logic                     out_valid, out_last, out_user;
   logic [DATA_BITS-1:0]     out_data;
   logic [DATA_BYTES-1:0]    out_keep;
   logic [ID_BITS-1:0]       out_id;
   logic                     unused_tid;

   rr_pick #(.NUM_PORTS(NUM_PORTS), .ID_BITS(ID_BITS)) u_pick (
      .req  (saxis.tvalid),
      .last (rr),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Granted lane and its running byte count (16-bit, saturating).
   assign in_valid   = saxis.tvalid[grant];
   assign in_last    = saxis.tlast[grant];
   assign in_user    = saxis.tuser[grant];
   assign in_data    = saxis.tdata[32'(grant) * DATA_BITS +: DATA_BITS];
   assign in_keep    = saxis.tkeep[32'(grant) * DATA_BYTES +: DATA_BYTES];
   assign out_ready  = !out_valid || maxis.tready;
   assign bytes_sum  = 17'(bytes) + 17'(popcount(KEEP_MAX'(in_keep)));
   assign bytes_next = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
   assign over       = 32'(bytes_next) > 32'(MAX_FRAME_BYTES);
   assign unused_tid = ^saxis.tid;

   always_ff @(posedge clock) begin
      if (!aresetn) state <= ARB_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready_c    = '0;
      accept     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_any) state_next = ARB_PASS;
         end
         ARB_PASS: begin
            ready_c[grant] = out_ready;
            accept         = in_valid && out_ready;
            if (accept) begin
               if (in_last)   state_next = ARB_IDLE;
               else if (over) state_next = ARB_DISCARD;
            end
         end
         ARB_DISCARD: begin
            ready_c[grant] = 1'b1;
            if (in_valid && in_last) state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   // Ready is forced low while reset is held, even before the state register has cleared.
   assign saxis.tready = aresetn ? ready_c : '0;

   always_ff @(posedge clock) begin
      if (!aresetn) begin
         grant           <= '0;
         rr              <= ID_BITS'(NUM_PORTS - 1);
         bytes           <= '0;
         truncated_count <= '0;
         out_valid       <= 1'b0;
         out_last        <= 1'b0;
         out_user        <= 1'b0;
         out_data        <= '0;
         out_keep        <= '0;
         out_id          <= '0;
      end else begin
         if (state == ARB_IDLE && pick_any) begin
            grant <= pick_idx;
            rr    <= pick_idx;
         end
         if (state_next == ARB_IDLE) bytes <= '0;
         else if (accept)            bytes <= bytes_next;
         if (accept && over && truncated_count != 32'hFFFF_FFFF)
            truncated_count <= truncated_count + 32'd1;
         if (out_ready) begin
            out_valid <= accept;
            if (accept) begin
               out_data <= in_data;
               out_keep <= in_keep;
               out_last <= in_last || over;
               out_user <= in_user || over;
               out_id   <= grant;
            end
         end
      end
   end

   assign maxis.tdata  = out_data;
   assign maxis.tkeep  = out_keep;
   assign maxis.tvalid = out_valid;
   assign maxis.tlast  = out_last;
   assign maxis.tuser  = out_user;
   assign maxis.tid    = out_id;

endmodule
